// File: rtl/quad_bbox_setup.sv
// ---------------------------------------------------------------------------
// quad_bbox_setup: clamped screen bounding box, nearest Z and off-screen flag per quad.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module quad_bbox_setup #(
  parameter int FRAC_BITS = 8,
  parameter int SCR_W     = 640,
  parameter int SCR_H     = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [20:0] vtx1_X_scaled,
  input  logic signed [20:0] vtx1_Y_scaled,
  input  logic signed [20:0] vtx1_Z_scaled,
  input  logic signed [20:0] vtx2_X_scaled,
  input  logic signed [20:0] vtx2_Y_scaled,
  input  logic signed [20:0] vtx2_Z_scaled,
  input  logic signed [20:0] vtx3_X_scaled,
  input  logic signed [20:0] vtx3_Y_scaled,
  input  logic signed [20:0] vtx3_Z_scaled,
  input  logic signed [20:0] vtx4_X_scaled,
  input  logic signed [20:0] vtx4_Y_scaled,
  input  logic signed [20:0] vtx4_Z_scaled,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [9:0]         bbox_xmin,
  output logic [9:0]         bbox_xmax,
  output logic [9:0]         bbox_ymin,
  output logic [9:0]         bbox_ymax,
  output logic signed [20:0] z_min,
  output logic               bbox_empty
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    CLAMP = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic signed [13:0] HALF_W    = 14'(SCR_W / 2);
  localparam logic signed [13:0] HALF_H_M1 = 14'(SCR_H / 2 - 1);
  localparam logic signed [13:0] X_MAX     = 14'(SCR_W - 1);
  localparam logic signed [13:0] Y_MAX     = 14'(SCR_H - 1);

  state_t             state;
  logic [1:0]         idx;
  logic signed [20:0] vx [4];
  logic signed [20:0] vy [4];
  logic signed [20:0] vz [4];
  logic signed [13:0] xmin, xmax, ymin, ymax;
  logic signed [20:0] zmin;

  logic signed [20:0] cur_x, cur_y, cur_z;
  logic signed [13:0] px, py;
  logic               off_screen;

  assign cur_x = vx[idx];
  assign cur_y = vy[idx];
  assign cur_z = vz[idx];

  // Screen-centred fixed point to top-left-origin pixels; >>> floors negatives.
  assign px = HALF_W + 14'(cur_x >>> FRAC_BITS);
  assign py = HALF_H_M1 - 14'(cur_y >>> FRAC_BITS);

  assign off_screen = xmax[13] || (xmin > X_MAX) || ymax[13] || (ymin > Y_MAX);

  function automatic logic [9:0] clamp_to(input logic signed [13:0] v,
                                          input logic signed [13:0] hi);
    if (v[13])
      return 10'd0;
    else if (v > hi)
      return hi[9:0];
    return v[9:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 2'd0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      bbox_xmin  <= 10'd0;
      bbox_xmax  <= 10'd0;
      bbox_ymin  <= 10'd0;
      bbox_ymax  <= 10'd0;
      z_min      <= 21'sd0;
      bbox_empty <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            vx[0] <= vtx1_X_scaled;  vy[0] <= vtx1_Y_scaled;  vz[0] <= vtx1_Z_scaled;
            vx[1] <= vtx2_X_scaled;  vy[1] <= vtx2_Y_scaled;  vz[1] <= vtx2_Z_scaled;
            vx[2] <= vtx3_X_scaled;  vy[2] <= vtx3_Y_scaled;  vz[2] <= vtx3_Z_scaled;
            vx[3] <= vtx4_X_scaled;  vy[3] <= vtx4_Y_scaled;  vz[3] <= vtx4_Z_scaled;
            idx      <= 2'd0;
            in_ready <= 1'b0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          // The first vertex seeds the extrema so an aborted quad leaves no residue.
          if (idx == 2'd0) begin
            xmin <= px;  xmax <= px;
            ymin <= py;  ymax <= py;
            zmin <= cur_z;
          end else begin
            if (px < xmin)    xmin <= px;
            if (px > xmax)    xmax <= px;
            if (py < ymin)    ymin <= py;
            if (py > ymax)    ymax <= py;
            if (cur_z < zmin) zmin <= cur_z;
          end
          idx <= idx + 2'd1;
          if (idx == 2'd3)
            state <= CLAMP;
        end
        CLAMP: begin
          bbox_empty <= off_screen;
          z_min      <= zmin;
          bbox_xmin  <= off_screen ? 10'd0 : clamp_to(xmin, X_MAX);
          bbox_xmax  <= off_screen ? 10'd0 : clamp_to(xmax, X_MAX);
          bbox_ymin  <= off_screen ? 10'd0 : clamp_to(ymin, Y_MAX);
          bbox_ymax  <= off_screen ? 10'd0 : clamp_to(ymax, Y_MAX);
          out_valid  <= 1'b1;
          state      <= OUT;
        end
        OUT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/quad_bbox_setup.md
Name: quad_bbox_setup

Overview:
- Sequential stage directly downstream of the vertex scaling stage.
- Accepts one quad (4 vertices of scaled, screen-centred signed fixed-point X/Y/Z) per handshake.
- Converts X/Y to integer pixel coordinates (origin top-left, Y down) and scans the vertices one per cycle.
- Emits the clamped screen bounding box, nearest Z and an off-screen flag to the rasteriser.

Parameters:
- FRAC_BITS, 8: fractional bits of the scaled X/Y inputs.
- SCR_W, 640: screen width in pixels.
- SCR_H, 480: screen height in pixels.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  quad valid.
- in_ready  out  1  block can accept a quad.
- vtx1_X_scaled, vtx1_Y_scaled, vtx1_Z_scaled  in  21 each  signed, vertex 1.
- vtx2_X_scaled, vtx2_Y_scaled, vtx2_Z_scaled  in  21 each  signed, vertex 2.
- vtx3_X_scaled, vtx3_Y_scaled, vtx3_Z_scaled  in  21 each  signed, vertex 3.
- vtx4_X_scaled, vtx4_Y_scaled, vtx4_Z_scaled  in  21 each  signed, vertex 4.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- bbox_xmin, bbox_xmax  out  10  unsigned pixel column, 0..SCR_W-1.
- bbox_ymin, bbox_ymax  out  10  unsigned pixel row, 0..SCR_H-1.
- z_min  out  21  signed smallest Z of the quad.
- bbox_empty  out  1  quad fully off-screen.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, in_ready=1, out_valid=0, all bbox outputs, z_min and bbox_empty=0.
  - Reset mid-operation discards the quad in flight.
- FSM states: IDLE, SCAN, CLAMP, OUT.
  - IDLE: in_ready=1. On in_valid&&in_ready, register all 12 inputs, reset the scan index to 0, go to SCAN.
  - SCAN: 4 cycles, one vertex per cycle in order 1..4. At the 4th edge, go to CLAMP.
  - CLAMP: 1 cycle. Register outputs, set out_valid=1, go to OUT.
  - OUT: outputs held stable while out_valid=1. On out_valid&&out_ready, clear out_valid and go to IDLE.
- in_ready is 0 in SCAN, CLAMP and OUT. in_valid is ignored there (no buffering).
- Latency: out_valid rises 5 edges after the accepting edge.
  - Throughput with out_ready tied high: one quad per 7 cycles.
- Pixel conversion:
  - px = SCR_W/2 + (X >>> FRAC_BITS).
  - py = SCR_H/2 - 1 - (Y >>> FRAC_BITS).
  - Arithmetic shift gives floor for negative values.
  - Compute in 14-bit signed; no overflow is possible for 21-bit inputs.
- Running minimum/maximum during SCAN:
  - First vertex initialises xmin/xmax/ymin/ymax/zmin.
  - Later vertices update with signed compares; on ties the value is unchanged.
- CLAMP stage:
  - bbox_empty=1 if xmax<0, xmin>SCR_W-1, ymax<0 or ymin>SCR_H-1. When empty, bbox outputs are forced to 0 and z_min is still valid.
  - Otherwise each bound is clamped to [0, SCR_W-1] or [0, SCR_H-1] and truncated to 10 bits.
- Degenerate quads (all vertices equal) give xmin==xmax and ymin==ymax, with bbox_empty=0 if on-screen.

Test Plan:
- Reset, then quad at pixels X/Y = (-160,120),(160,120),(160,-120),(-160,-120) (inputs ×256), Z = 100,200,300,50, out_ready=1 -> out_valid 5 edges after accept; xmin=160, xmax=480, ymin=119, ymax=359, z_min=50, bbox_empty=0.
- Negative fraction: all four X=-128 (-0.5), Y=0 -> xmin=xmax=319, ymin=ymax=239.
- Clamp and empty cases:
  - X in {-400, 400}, Y in {-300, 300} -> bbox 0..639 × 0..479, empty=0.
  - All X ≥ 320.0 -> bbox_empty=1, bbox outputs 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, and pulse in_valid with a different quad -> outputs stable, in_ready=0, second quad not accepted. Release -> IDLE on the next edge.
- Reset asserted during the 2nd SCAN cycle -> next edge: in_ready=1, out_valid=0. A new quad is then processed correctly with no residue from the aborted one.
- Back-to-back: in_valid and out_ready tied high for 3 quads -> accepts exactly every 7 cycles, results in order.
